risc_spm_core_param: RTL and testbench
======================================

// Module: risc_spm_core_param
// PURPOSE
//  Parametrised multi-cycle RISC stored-program core: controller FSM, NUM_REGS register file, ALU and PC in one block.
//  Memory is external over a req/ready handshake, so memories with wait states attach directly.
//  Adds HALT, illegal-opcode trap, retire pulse and a debug register read port.
//  Sits under the SoC top, beside the memory unit.
// PARAMETERS
//  WORD_SIZE  8  data, instruction, address and PC width; must satisfy WORD_SIZE >= 4 + 2*log2(NUM_REGS)
//  NUM_REGS   4  general registers R0..R(N-1); power of two, >= 2
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              reset, synchronous, active-high
//  mem_req      out  1              memory transfer request
//  mem_we       out  1              1 = write, 0 = read; valid while mem_req=1
//  mem_addr     out  WORD_SIZE      transfer address
//  mem_wdata    out  WORD_SIZE      write data
//  mem_rdata    in   WORD_SIZE      read data; valid when mem_ready=1
//  mem_ready    in   1              transfer completes on an edge where mem_req and mem_ready are both 1
//  halted       out  1              core is in HALT
//  illegal      out  1              sticky; halt was caused by an undefined opcode
//  zero         out  1              Z flag
//  pc           out  WORD_SIZE      current PC
//  retire       out  1              1-cycle pulse on each completed instruction
//  dbg_sel      in   log2(NUM_REGS) debug register select
//  dbg_data     out  WORD_SIZE      R[dbg_sel], combinational
// BEHAVIOUR
//  Encoding: op = IR[W-1:W-4]; src = next log2(N) bits down; dest = log2(N) bits below src; remaining bits ignored.
//  Opcodes (1 word):
//   0 NOP
//   1 ADD: dest = dest + src
//   2 SUB: dest = dest - src
//   3 AND: dest = dest & src
//   4 NOT: dest = ~src
//   F HALT
//  Opcodes (2 words, second word A):
//   5 RD: dest = mem[A]
//   6 WR: mem[A] = src
//   7 BR: PC = A
//   8 BRZ: PC = A if Z=1, else continue
//  Opcodes 9..E are illegal: go to HALT and set illegal=1.
//  Arithmetic is modulo 2^WORD_SIZE; carry/borrow discarded. Z is set iff the ALU result is 0.
//  Only ADD/SUB/AND/NOT update Z. PC increments wrap 2^W-1 -> 0.
//  Handshake:
//   - While mem_req=1, addr/we/wdata are held stable until completion.
//   - mem_ready is ignored when mem_req=0.
//   - After completion, mem_req may stay high only for the next transfer.
//  FSM:
//   IDLE   1 cycle after reset -> FETCH.
//   FETCH  req, addr=PC, we=0. On ready: IR <= rdata, PC++ -> DECODE.
//   DECODE 1-word ops execute here (reg write and Z at this edge), retire -> FETCH.
//          HALT/illegal -> HALT. 2-word ops -> OPND.
//   OPND   req, addr=PC, we=0. On ready: AR <= rdata.
//          BR: PC = rdata, retire -> FETCH.
//          BRZ: PC = Z ? rdata : PC+1, retire -> FETCH.
//          RD/WR: PC++ -> DATA.
//   DATA   req, addr=AR, we=(op==WR), wdata=R[src]. On ready: RD writes R[dest], retire -> FETCH.
//   HALT   mem_req=0, halted=1, retire pulses once on entry; held until rst.
//  Latency with zero-wait memory: 1-word op = 2 cycles; BR/BRZ = 3; RD/WR = 4. Each wait cycle adds 1.
//  Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, halted 0, illegal 0, zero 0, pc 0, retire 0, all R = 0.
//  Reset mid-transfer aborts it; mem_req is 0 from the next cycle and no register/PC update occurs.
//  src == dest is legal (e.g. SUB R1,R1 -> 0, Z=1).
// TESTING
//  T1 W=8,N=4, ready=1: mem[0]=50 (RD R0), [1]=20, [0x20]=05, [2]=11 (ADD R0->R1) twice, [4]=FF
//     -> R1=0A, zero=0, halted at cycle 4+2+2+2, pc=05.
//  T2 SUB R1,R1 (25) then BRZ 0x40 (80,40); [0x40]=FF
//     -> zero=1, pc=40 after BRZ, halted=1, illegal=0.
//  T3 ready low for 3 cycles in FETCH
//     -> mem_req, mem_addr stable all 4 cycles; IR/PC unchanged until the ready edge.
//  T4 R2=A5, WR R2 (68), addr 0x30 -> DATA cycle: mem_we=1, mem_addr=30, mem_wdata=A5; zero unchanged.
//  T5 opcode 0x9x -> halted=1, illegal=1, mem_req=0 for all later cycles; rst clears both flags.
//  T6 rst asserted with mem_req=1 during OPND -> next cycle mem_req=0, pc=00, R unchanged vs reset=0; PC wrap FF->00 on fetch.

Source files
------------

// File: rtl/risc_spm_core_param.sv
// risc_spm_core_param: multi-cycle stored-program RISC core with a req/ready memory port
module risc_spm_core_param #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WORD_SIZE-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0]        mem_wdata,
  input  logic [WORD_SIZE-1:0]        mem_rdata,
  input  logic                        mem_ready,
  output logic                        halted,
  output logic                        illegal,
  output logic                        zero,
  output logic [WORD_SIZE-1:0]        pc,
  output logic                        retire,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [WORD_SIZE-1:0]        dbg_data
);
  localparam int RW = $clog2(NUM_REGS);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPND, DATA, HALT} state_t;
  state_t state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d, ir_q, ir_d, ar_q, ar_d, alu;
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
  logic z_q, z_d, ill_q, ill_d, ret_q, ret_d;
  logic [3:0] op;
  logic [RW-1:0] src, dest;
  assign op   = ir_q[WORD_SIZE-1 -: 4];
  assign src  = ir_q[WORD_SIZE-5 -: RW];
  assign dest = ir_q[WORD_SIZE-5-RW -: RW];
  assign alu  = op == 4'h1 ? regs_q[dest] + regs_q[src] :
                op == 4'h2 ? regs_q[dest] - regs_q[src] :
                op == 4'h3 ? regs_q[dest] & regs_q[src] : ~regs_q[src];
  assign mem_req   = state_q inside {FETCH, OPND, DATA};
  assign mem_we    = state_q == DATA && op == 4'h6;
  assign mem_addr  = state_q == DATA ? ar_q : pc_q;
  assign mem_wdata = state_q == DATA ? regs_q[src] : '0;
  assign halted    = state_q == HALT;
  assign illegal   = ill_q;
  assign zero      = z_q;
  assign pc        = pc_q;
  assign retire    = ret_q;
  assign dbg_data  = regs_q[dbg_sel];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;
    regs_d  = regs_q;
    z_d     = z_q;
    ill_d   = ill_q;
    ret_d   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (op inside {[4'h1:4'h4]}) begin
          regs_d[dest] = alu;
          z_d          = alu == '0;
        end
        state_d = op inside {[4'h5:4'h8]} ? OPND : op > 4'h8 ? HALT : FETCH;
        ill_d   = ill_q | (op > 4'h8 && op != 4'hF);
        ret_d   = !(op inside {[4'h5:4'h8]});
      end
      // operand word: branches finish here, RD/WR latch the data address
      OPND: if (mem_ready) begin
        ar_d    = mem_rdata;
        pc_d    = op == 4'h7 || (op == 4'h8 && z_q) ? mem_rdata : pc_q + 1'b1;
        state_d = op inside {4'h7, 4'h8} ? FETCH : DATA;
        ret_d   = op inside {4'h7, 4'h8};
      end
      DATA: if (mem_ready) begin
        if (op == 4'h5) regs_d[dest] = mem_rdata;
        ret_d   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ar_q    <= '0;
      regs_q  <= '{default: '0};
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      regs_q  <= regs_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
      ret_q   <= ret_d;
    end
  end
endmodule

// File: tb/tb_risc_spm_core_param.sv
// tb_risc_spm_core_param: scoreboard bench driving the core with an ISA-level reference model
module tb_risc_spm_core_param;
  typedef struct packed {
    logic [7:0]  pc;
    logic        z;
    logic        h;
    logic        il;
    logic [31:0] r;
  } exp_t;
  logic clk, rst, mem_req, mem_we, mem_ready, halted, illegal, zero, retire;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data;
  logic [1:0] dbg_sel;
  logic [7:0] mem [256];
  logic [7:0] mm [256];
  exp_t sb [$];
  logic [15:0] wq [$];
  int total = 0, bad = 0, rmode = 0, exp_cyc = 0;
  bit active = 0, exp_h = 0;
  risc_spm_core_param #(.WORD_SIZE(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .illegal(illegal), .zero(zero), .pc(pc), .retire(retire), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  assign mem_rdata = mem[mem_addr];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, want);
    end
  endtask
  task automatic rd_reg(input int i, output logic [7:0] v);
    dbg_sel = 2'(i);
    #1 v = dbg_data;
  endtask
  // ISA-level model: executes instructions one at a time on a private memory copy
  task automatic run_model(input int nret);
    logic [7:0] pm, ir, a;
    logic [7:0] r [4];
    logic z, h, il;
    logic [3:0] op;
    logic [1:0] s, d;
    int lat;
    exp_t e;
    foreach (mem[i]) mm[i] = mem[i];
    pm = 0; z = 0; h = 0; il = 0;
    foreach (r[i]) r[i] = 0;
    exp_cyc = 1;
    for (int n = 0; n < nret && !h; n++) begin
      ir = mm[pm]; pm = pm + 8'd1;
      op = ir[7:4]; s = ir[3:2]; d = ir[1:0]; lat = 2;
      case (op)
        4'h0: ;
        4'h1: begin r[d] = r[d] + r[s]; z = r[d] == 0; end
        4'h2: begin r[d] = r[d] - r[s]; z = r[d] == 0; end
        4'h3: begin r[d] = r[d] & r[s]; z = r[d] == 0; end
        4'h4: begin r[d] = ~r[s]; z = r[d] == 0; end
        4'h5: begin a = mm[pm]; pm = pm + 8'd1; r[d] = mm[a]; lat = 4; end
        4'h6: begin a = mm[pm]; pm = pm + 8'd1; mm[a] = r[s]; wq.push_back({a, r[s]}); lat = 4; end
        4'h7: begin pm = mm[pm]; lat = 3; end
        4'h8: begin pm = z ? mm[pm] : pm + 8'd1; lat = 3; end
        4'hF: h = 1;
        default: begin h = 1; il = 1; end
      endcase
      exp_cyc += lat;
      e.pc = pm; e.z = z; e.h = h; e.il = il;
      for (int i = 0; i < 4; i++) e.r[i*8 +: 8] = r[i];
      sb.push_back(e);
    end
    exp_h = h;
  endtask
  task automatic prog_begin();
    @(negedge clk);
    rst = 1; active = 0;
    sb.delete(); wq.delete();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask
  task automatic prog_go(input int mode, input int nret, input int budget);
    int cyc, hc;
    run_model(nret);
    rmode = mode;
    repeat (2) @(negedge clk);
    active = 1; rst = 0; cyc = 0; hc = 0;
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (halted && hc == 0) hc = cyc;
    end
    check("drain", 64'(sb.size()), 0);
    @(posedge clk);
    active = 0;
    check("writes_left", 64'(wq.size()), 0);
    if (mode == 0 && exp_h) check("latency", 64'(hc), 64'(exp_cyc));
    if (exp_h) repeat (3) begin
      @(negedge clk);
      check("post_halt", {mem_req, halted}, 2'b01);
    end
  endtask
  task automatic reset_check();
    logic [7:0] v;
    check("rst_outs", {mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, zero, pc, retire}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      check("rst_reg", v, 0);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) mem_ready = 1;
    else if (rmode == 1) mem_ready = $urandom_range(0, 1) == 1;
  end
  // scoreboard monitor: every retire pulse pops one expected architectural state
  initial begin
    exp_t e;
    logic [31:0] g;
    forever begin
      @(negedge clk);
      if (retire && active && !rst) begin
        if (sb.size() == 0) check("extra_retire", 1, 0);
        else begin
          e = sb.pop_front();
          for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 g[i*8 +: 8] = dbg_data;
          end
          check("retire_state", {pc, zero, halted, illegal, g}, e);
        end
      end
    end
  end
  // memory side: handshake hold rules and write completion
  initial begin
    logic pend, pwe;
    logic [7:0] paddr, pwd, ppc;
    logic [15:0] w;
    pend = 0; pwe = 0; paddr = 0; pwd = 0; ppc = 0;
    forever begin
      @(negedge clk);
      if (pend && !rst)
        check("hs_hold", {mem_req, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00, pc},
              {1'b1, pwe, paddr, pwe ? pwd : 8'h00, ppc});
      pend = mem_req && !mem_ready && !rst;
      paddr = mem_addr; pwe = mem_we; pwd = mem_wdata; ppc = pc;
      if (mem_req && mem_ready && mem_we && !rst) begin
        mem[mem_addr] = mem_wdata;
        if (active) begin
          if (wq.size() == 0) check("extra_write", 1, 0);
          else begin
            w = wq.pop_front();
            check("mem_write", {mem_addr, mem_wdata}, w);
          end
        end
      end
    end
  end
  initial begin
    logic [7:0] v;
    int r, cyc;
    logic [3:0] op;
    rst = 1; mem_ready = 0; dbg_sel = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_check();
    prog_begin();
    mem[0] = 8'h50; mem[1] = 8'h20; mem[8'h20] = 8'h05; mem[2] = 8'h11; mem[3] = 8'h11; mem[4] = 8'hFF;
    prog_go(0, 50, 100);
    rd_reg(1, v);
    check("t1_r1", v, 8'h0A);
    check("t1_pc_zero", {pc, zero}, {8'h05, 1'b0});
    prog_begin();
    mem[0] = 8'h50; mem[1] = 8'h20; mem[8'h20] = 8'h05; mem[2] = 8'h11; mem[3] = 8'h11; mem[4] = 8'hFF;
    prog_go(1, 50, 400);
    rd_reg(1, v);
    check("t3_r1", v, 8'h0A);
    prog_begin();
    mem[0] = 8'h25; mem[1] = 8'h80; mem[2] = 8'h40; mem[8'h40] = 8'hFF;
    prog_go(0, 50, 100);
    check("t2_flags", {zero, halted, illegal, pc}, {3'b110, 8'h41});
    prog_begin();
    mem[0] = 8'h52; mem[1] = 8'h10; mem[8'h10] = 8'hA5; mem[2] = 8'h68; mem[3] = 8'h30; mem[4] = 8'hFF;
    prog_go(1, 50, 400);
    check("t4_mem", mem[8'h30], 8'hA5);
    check("t4_zero", zero, 0);
    prog_begin();
    mem[0] = 8'h93;
    prog_go(0, 50, 100);
    check("t5_flags", {halted, illegal}, 2'b11);
    prog_begin();
    @(negedge clk);
    reset_check();
    prog_begin();
    mem[0] = 8'h70; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    rmode = 2; mem_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0; cyc = 0;
    while (!(mem_req && mem_addr == 8'h01) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_opnd_seen", {mem_req, mem_addr}, {1'b1, 8'h01});
    mem_ready = 0; rst = 1;
    @(negedge clk);
    check("t6_abort", {mem_req, pc}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      check("t6_reg", v, 0);
    end
    prog_begin();
    mem[0] = 8'h70; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    prog_go(0, 5, 100);
    for (int k = 0; k < 6; k++) begin
      prog_begin();
      foreach (mem[i]) begin
        r = $urandom_range(0, 99);
        op = r < 88 ? 4'($urandom_range(0, 8)) : r < 94 ? 4'hF : 4'($urandom_range(9, 14));
        mem[i] = {op, 4'($urandom)};
      end
      prog_go(k % 2, 40, 2000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
